// File: rtl/line_rasterizer.sv
// Bresenham line engine that writes one pixel per clock into a 1-bit frame buffer.
// The buffer address is {x, y}. The engine reports busy while it works and pulses done when the line is finished.
module line_rasterizer #(
   parameter int XW = 10,
   parameter int YW = 9,
   parameter int EW = 13
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [XW-1:0] x0,
   input  logic [YW-1:0] y0,
   input  logic [XW-1:0] x1,
   input  logic [YW-1:0] y1,
   input  logic          color,
   output logic          busy,
   output logic          done,
   output logic          vid_we,
   output logic [XW+YW-1:0] vid_addr,
   output logic          vid_data
);

   typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;

   state_t state_q, state_d;

   logic [XW-1:0] x0_q, x1_q, cur_x;
   logic [YW-1:0] y0_q, y1_q, cur_y;
   logic          color_q;
   logic          sx_neg, sy_neg;
   logic signed [EW-1:0] dx_q, dy_q, err_q;
   logic [XW+YW-1:0] last_addr;
   logic          last_data;

   logic signed [EW-1:0] diff_x, diff_y, abs_x, abs_y;
   logic signed [EW-1:0] e2, err_n;
   logic          step_x, step_y, at_end;

   // Endpoint deltas are formed from zero-extended coordinates so the signed math never overflows.
   always_comb begin
      diff_x = $signed({{(EW-XW){1'b0}}, x1_q}) - $signed({{(EW-XW){1'b0}}, x0_q});
      diff_y = $signed({{(EW-YW){1'b0}}, y1_q}) - $signed({{(EW-YW){1'b0}}, y0_q});
      abs_x  = diff_x[EW-1] ? -diff_x : diff_x;
      abs_y  = diff_y[EW-1] ? -diff_y : diff_y;
   end

   always_comb begin
      e2     = err_q <<< 1;
      step_x = (e2 >= dy_q);
      step_y = (e2 <= dx_q);
      err_n  = err_q;
      if (step_x) err_n = err_n + dy_q;
      if (step_y) err_n = err_n + dx_q;
      at_end = (cur_x == x1_q) && (cur_y == y1_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = INIT;
         INIT:    state_d = DRAW;
         DRAW:    if (at_end) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x0_q      <= '0;
         y0_q      <= '0;
         x1_q      <= '0;
         y1_q      <= '0;
         color_q   <= 1'b0;
         cur_x     <= '0;
         cur_y     <= '0;
         sx_neg    <= 1'b0;
         sy_neg    <= 1'b0;
         dx_q      <= '0;
         dy_q      <= '0;
         err_q     <= '0;
         last_addr <= '0;
         last_data <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  x0_q    <= x0;
                  y0_q    <= y0;
                  x1_q    <= x1;
                  y1_q    <= y1;
                  color_q <= color;
               end
            end
            INIT: begin
               dx_q   <= abs_x;
               dy_q   <= -abs_y;
               err_q  <= abs_x - abs_y;
               sx_neg <= !(x0_q < x1_q);
               sy_neg <= !(y0_q < y1_q);
               cur_x  <= x0_q;
               cur_y  <= y0_q;
            end
            DRAW: begin
               // Remember the pixel just presented so the bus holds it once drawing stops.
               last_addr <= {cur_x, cur_y};
               last_data <= color_q;
               if (!at_end) begin
                  err_q <= err_n;
                  if (step_x) cur_x <= sx_neg ? cur_x - 1'b1 : cur_x + 1'b1;
                  if (step_y) cur_y <= sy_neg ? cur_y - 1'b1 : cur_y + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy     = (state_q != IDLE);
      done     = (state_q == DONE);
      vid_we   = (state_q == DRAW);
      vid_addr = vid_we ? {cur_x, cur_y} : last_addr;
      vid_data = vid_we ? color_q : last_data;
   end

endmodule

// File: tb/tb_line_rasterizer.sv
// Self-checking bench for line_rasterizer: directed scenarios plus random lines compared against a Bresenham pixel list.
module tb_line_rasterizer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  x0 = '0, x1 = '0;
   logic [8:0]  y0 = '0, y1 = '0;
   logic        color = 1'b0;
   logic        busy, done, vid_we, vid_data;
   logic [18:0] vid_addr;

   int total = 0;
   int bad = 0;

   int cap_addr[$];
   int cap_data[$];
   int exp_addr[$];
   int first_k, done_cnt, done_k, busy_after, timed_out;

   line_rasterizer #(.XW(10), .YW(9), .EW(13)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
      .busy(busy), .done(done), .vid_we(vid_we),
      .vid_addr(vid_addr), .vid_data(vid_data)
   );

   always #5 clk = ~clk;

   // Pixel list of the line, walked as the textbook integer Bresenham loop over plain ints.
   task automatic build_expected(input int ax0, input int ay0, input int ax1, input int ay1);
      int dx, dy, sx, sy, err, e2, cx, cy;
      exp_addr.delete();
      dx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
      dy = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
      sx = (ax0 < ax1) ? 1 : -1;
      sy = (ay0 < ay1) ? 1 : -1;
      err = dx + dy;
      cx = ax0;
      cy = ay0;
      for (int n = 0; n < 4000; n++) begin
         exp_addr.push_back(cx * 512 + cy);
         if (cx == ax1 && cy == ay1) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; cx += sx; end
         if (e2 <= dx) begin err += dx; cy += sy; end
      end
   endtask

   // Issues one request and records every write, the done pulses and the state just after done.
   task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                           input logic c, input int inj_k);
      cap_addr.delete();
      cap_data.delete();
      first_k = -1; done_cnt = 0; done_k = -1; busy_after = -1; timed_out = 1;
      @(negedge clk);
      x0 = 10'(ax0); y0 = 9'(ay0); x1 = 10'(ax1); y1 = 9'(ay1); color = c;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 3000; k++) begin
         @(negedge clk);
         if (inj_k != 0 && k == inj_k) begin
            start = 1'b1;
            x0 = 10'($urandom); y0 = 9'($urandom); x1 = 10'($urandom); y1 = 9'($urandom);
            color = ~c;
         end else if (inj_k != 0 && k == inj_k + 1) begin
            start = 1'b0;
         end
         if (vid_we) begin
            if (first_k < 0) first_k = k;
            cap_addr.push_back(int'(vid_addr));
            cap_data.push_back(int'(vid_data));
         end
         if (done) begin
            done_cnt++;
            done_k = k;
         end else if (done_cnt > 0) begin
            busy_after = int'(busy);
            timed_out = 0;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      #3;
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
      total++; if (vid_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_we got=%b want=0", vid_we); end
      total++; if (vid_addr !== 19'd0) begin bad++; $display("[TB] FAIL reset_addr got=%0d want=0", vid_addr); end
      total++; if (vid_data !== 1'b0) begin bad++; $display("[TB] FAIL reset_data got=%b want=0", vid_data); end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_horizontal;
      int mism = 0;
      exp_addr = '{0, 512, 1024, 1536};
      run_line(0, 0, 3, 0, 1'b1, 0);
      total++; if (timed_out != 0) begin bad++; $display("[TB] FAIL horiz_timeout got=%0d want=0", timed_out); end
      total++; if (first_k != 2) begin bad++; $display("[TB] FAIL horiz_latency got=%0d want=2", first_k); end
      total++; if (cap_addr.size() != 4) begin bad++; $display("[TB] FAIL horiz_count got=%0d want=4", cap_addr.size()); end
      foreach (exp_addr[i]) if (i >= cap_addr.size() || cap_addr[i] != exp_addr[i] || cap_data[i] != 1) mism++;
      total++; if (mism != 0) begin bad++; $display("[TB] FAIL horiz_pixels got=%0d wrong want=0", mism); end
      total++; if (done_k != 6 || done_cnt != 1) begin bad++; $display("[TB] FAIL horiz_done got=k%0d/n%0d want=k6/n1", done_k, done_cnt); end
      total++; if (busy_after != 0) begin bad++; $display("[TB] FAIL horiz_busy_drop got=%0d want=0", busy_after); end
      total++; if (vid_addr !== 19'd1536) begin bad++; $display("[TB] FAIL horiz_addr_hold got=%0d want=1536", vid_addr); end
   endtask

   task automatic test_steep;
      int mism = 0;
      exp_addr = '{0, 1, 514, 515};
      run_line(0, 0, 1, 3, 1'b1, 0);
      total++; if (cap_addr.size() != 4) begin bad++; $display("[TB] FAIL steep_count got=%0d want=4", cap_addr.size()); end
      foreach (exp_addr[i]) if (i >= cap_addr.size() || cap_addr[i] != exp_addr[i]) mism++;
      total++; if (mism != 0) begin bad++; $display("[TB] FAIL steep_pixels got=%0d wrong want=0", mism); end
      total++; if (done_k != first_k + 4) begin bad++; $display("[TB] FAIL steep_gapless got=%0d want=%0d", done_k, first_k + 4); end
   endtask

   task automatic test_reverse_diag;
      int mism = 0;
      exp_addr = '{2565, 2052, 1539, 1026};
      run_line(5, 5, 2, 2, 1'b1, 0);
      total++; if (cap_addr.size() != 4) begin bad++; $display("[TB] FAIL rdiag_count got=%0d want=4", cap_addr.size()); end
      foreach (exp_addr[i]) if (i >= cap_addr.size() || cap_addr[i] != exp_addr[i]) mism++;
      total++; if (mism != 0) begin bad++; $display("[TB] FAIL rdiag_pixels got=%0d wrong want=0", mism); end
   endtask

   task automatic test_corner_point;
      run_line(1023, 511, 1023, 511, 1'b0, 0);
      total++; if (cap_addr.size() != 1) begin bad++; $display("[TB] FAIL corner_count got=%0d want=1", cap_addr.size()); end
      total++; if (cap_addr.size() < 1 || cap_addr[0] != 'h7FFFF || cap_data[0] != 0) begin
         bad++; $display("[TB] FAIL corner_pixel got=%0d entries want=addr 0x7FFFF data 0", cap_addr.size()); end
      total++; if (done_k != 3 || done_cnt != 1) begin bad++; $display("[TB] FAIL corner_done got=k%0d/n%0d want=k3/n1", done_k, done_cnt); end
   endtask

   task automatic test_start_while_busy;
      int mism = 0;
      exp_addr = '{0, 512, 1024, 1536};
      run_line(0, 0, 3, 0, 1'b1, 3);
      total++; if (cap_addr.size() != 4) begin bad++; $display("[TB] FAIL busy_start_count got=%0d want=4", cap_addr.size()); end
      foreach (exp_addr[i]) if (i >= cap_addr.size() || cap_addr[i] != exp_addr[i] || cap_data[i] != 1) mism++;
      total++; if (mism != 0) begin bad++; $display("[TB] FAIL busy_start_pixels got=%0d wrong want=0", mism); end
      total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL busy_start_done got=%0d want=1", done_cnt); end
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_start_queued got=%b want=0", busy); end
   endtask

   task automatic test_reset_mid_line;
      int writes = 0;
      @(negedge clk);
      x0 = 10'd0; y0 = 9'd0; x1 = 10'd3; y1 = 9'd0; color = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k < 20 && writes < 2; k++) begin
         @(negedge clk);
         if (vid_we) writes++;
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++; if (vid_we !== 1'b0) begin bad++; $display("[TB] FAIL midreset_we got=%b want=0", vid_we); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy got=%b want=0", busy); end
      total++; if (vid_addr !== 19'd0) begin bad++; $display("[TB] FAIL midreset_addr got=%0d want=0", vid_addr); end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      build_expected(2, 7, 6, 9);
      run_line(2, 7, 6, 9, 1'b1, 0);
      total++; if (cap_addr != exp_addr || first_k != 2 || done_cnt != 1) begin
         bad++; $display("[TB] FAIL midreset_restart got=%0d writes first=%0d want=%0d writes first=2", cap_addr.size(), first_k, exp_addr.size()); end
   endtask

   task automatic test_random;
      int ax0, ay0, ax1, ay1, mism;
      logic c;
      for (int t = 0; t < 24; t++) begin
         if (t % 3 == 0) begin
            ax0 = $urandom_range(1023); ay0 = $urandom_range(511);
            ax1 = $urandom_range(1023); ay1 = $urandom_range(511);
         end else begin
            ax0 = $urandom_range(40); ay0 = $urandom_range(40);
            ax1 = $urandom_range(40); ay1 = $urandom_range(40);
         end
         c = 1'($urandom);
         build_expected(ax0, ay0, ax1, ay1);
         run_line(ax0, ay0, ax1, ay1, c, 0);
         mism = 0;
         foreach (exp_addr[i]) if (i >= cap_addr.size() || cap_addr[i] != exp_addr[i] || cap_data[i] != int'(c)) mism++;
         total++;
         if (mism != 0 || cap_addr.size() != exp_addr.size() || first_k != 2 || done_cnt != 1 || busy_after != 0) begin
            bad++;
            $display("[TB] FAIL random_line(%0d,%0d)->(%0d,%0d) got=%0d writes/%0d wrong want=%0d writes/0 wrong",
                     ax0, ay0, ax1, ay1, cap_addr.size(), mism, exp_addr.size());
         end
      end
   endtask

   initial begin
      test_reset();
      test_horizontal();
      test_steep();
      test_reverse_diag();
      test_corner_point();
      test_start_while_busy();
      test_reset_mid_line();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/line_rasterizer.md
Name: line_rasterizer

Overview:
- Bresenham line-drawing engine placed directly upstream of the 1-bit frame buffer; drives that buffer's write port.
- Accepts a line request, defined by two endpoints and a pixel value.
- Writes every pixel on the line at one pixel per clock, using addresses in the buffer's {x[9:0], y[8:0]} format.
- Reports busy/done to the command source, such as a CPU or command FSM.

Parameters:
- XW, 10, x coordinate width
- YW, 9, y coordinate width
- EW, 13, signed error-accumulator width (must be ≥ max(XW,YW)+3)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request strobe; sampled only when busy=0
- x0  in  XW  start-point x
- y0  in  YW  start-point y
- x1  in  XW  end-point x
- y1  in  YW  end-point y
- color  in  1  pixel value to write
- busy  out  1  high from the cycle after start is accepted until the end of the DONE cycle
- done  out  1  one-cycle pulse after the last pixel is written
- vid_we  out  1  frame-buffer write enable
- vid_addr  out  XW+YW  write address {cur_x, cur_y}
- vid_data  out  1  write data (latched color)

Behaviour:
- States:
  - IDLE: start=1 → latch x0,y0,x1,y1,color; go to INIT.
  - INIT: compute dx=|x1-x0|, dy=-|y1-y0|, sx=(x0<x1)?+1:-1, sy=(y0<y1)?+1:-1, err=dx+dy; set cur=(x0,y0); go to DRAW.
  - DRAW: one pixel per cycle; exits to DONE when cur==(x1,y1).
  - DONE: done=1 for one cycle; then IDLE.
- Inputs x0..color are captured at acceptance; later changes have no effect on a line in progress.
- busy=1 in INIT, DRAW and DONE. start is ignored while busy=1, with no queueing.
- Latency: start sampled at edge N → INIT during cycle N+1 → first vid_we=1 during cycle N+2.
- DRAW outputs (combinational from state and cur registers): vid_we=1, vid_addr={cur_x,cur_y}, vid_data=latched color. The buffer captures the pixel on the next rising edge.
- In all states other than DRAW: vid_we=0; vid_addr and vid_data hold their last values.
- DRAW step, applied at each edge while cur≠(x1,y1):
  - Compute e2=2*err, sign-extended to EW bits.
  - If e2≥dy: err+=dy; cur_x+=sx.
  - If e2≤dx: err+=dx; cur_y+=sy.
  - Both conditions may apply in one step; the err updates sum.
- Termination: the cycle that writes (x1,y1) is the last DRAW cycle. Number of vid_we cycles = max(dx,|dy|)+1.
- Degenerate line (x0,y0)==(x1,y1): exactly one write.
- Arithmetic: all difference and error math is signed, EW bits.
- Coordinates: the full XW/YW range is valid and there is no clipping. Coordinates never wrap, because the step stops at the endpoint.
- Reset (asynchronous, rst_n=0), including mid-line:
  - Immediately: state=IDLE, busy=0, done=0, vid_we=0, vid_addr=0, vid_data=0.
  - Internal registers are cleared to 0.
  - The partially drawn line is abandoned; pixels already written remain in the buffer.

Test Plan:
- Horizontal line:
  - Stimulus: start with (0,0)→(3,0), color=1.
  - Response: first write two cycles after the start edge; vid_addr=0,512,1024,1536 on four consecutive cycles; done pulses the next cycle; busy then drops.
- Steep line:
  - Stimulus: (0,0)→(1,3).
  - Response: writes at addresses 0, 1, 514, 515, in order, with no gaps.
- Reverse diagonal:
  - Stimulus: (5,5)→(2,2).
  - Response: {x,y} sequence (5,5),(4,4),(3,3),(2,2), i.e. addresses 2565, 2052, 1539, 1026.
- Single point and extreme corner:
  - Stimulus: (1023,511)→(1023,511), color=0.
  - Response: exactly one write, addr=0x7FFFF, data=0; done on the next cycle.
- Start while busy:
  - Stimulus: assert start with new endpoints during DRAW of line (0,0)→(3,0).
  - Response: the second request is ignored; only the original four addresses are written; exactly one done pulse.
- Reset mid-line:
  - Stimulus: drop rst_n after the second write of (0,0)→(3,0).
  - Response: vid_we and busy go to 0 without waiting for a clock edge. After release, the engine is IDLE and accepts a new start normally.
